// File: rtl/scpad_dram_rsp_fifo.sv
// In-order FWFT elastic buffer between the DRAM response channel and one scratchpad backend.
// DRAM is stalled early at DEPTH-SLACK entries so beats still in flight after the stall always fit.
module scpad_dram_rsp_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8,
  parameter int SLACK  = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_valid,
  input  logic [ID_W-1:0]            in_id,
  input  logic [DATA_W-1:0]          in_rdata,
  output logic                       dram_stall,
  output logic                       out_valid,
  output logic [ID_W-1:0]            out_id,
  output logic [DATA_W-1:0]          out_rdata,
  input  logic                       out_stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SLACK);

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [ID_W-1:0]   id_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic              full, pop, push;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & ~out_stall;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push      = in_valid & (~full | pop);

  assign out_id       = id_mem_q[rd_ptr_q];
  assign out_rdata    = data_mem_q[rd_ptr_q];
  assign dram_stall   = (count_q >= STALL_CNT);
  assign count        = count_q;
  assign overflow_err = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & full & ~pop & ~flush);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; out_* are only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      id_mem_q[wr_ptr_q]   <= in_id;
      data_mem_q[wr_ptr_q] <= in_rdata;
    end
  end

endmodule
